apb_regfile_slave: RTL and testbench



---
 rtl/apb_regfile_pkg.sv | 17 +
 rtl/apb_wait_ctr.sv | 27 ++
 rtl/apb_regfile_slave.sv | 126 ++++++++++++
 tb/tb_apb_regfile_slave.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/apb_regfile_pkg.sv
// Shared types and constants for the APB register-file slave.
// Optional byte-strobe writes are enabled by defining APB_REGFILE_PSTRB_EN.
package apb_regfile_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0001;

  // Number of paddr bits that select a byte inside one data word.
  function automatic int byteOffsetWidth(input int dataW);
    return $clog2(dataW / 8);
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter that inserts APB wait states.
// o_done is high whenever the count has reached zero.
module apb_wait_ctr #(
  parameter int W = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_loadValue,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_loadValue;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/apb_regfile_slave.sv
// Parametrised APB3 register-file slave; word 0 is a read-only ID word.
// Define APB_REGFILE_PSTRB_EN to make writes honour pstrb byte strobes.
module apb_regfile_slave
  import apb_regfile_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr
);

  localparam int OFFS_W = byteOffsetWidth(DATA_W);
  localparam int IDX_W  = ADDR_W - OFFS_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NBYTES = DATA_W / 8;
  localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(DEPTH);

  apb_state_t        r_state, w_nextState;
  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic              r_err;
  logic [DATA_W-1:0] r_wdata;
  logic [NBYTES-1:0] r_strb;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic              w_setup;
  logic              w_done;
  logic              w_commit;
  logic [NBYTES-1:0] w_strb;
  logic [DATA_W-1:0] w_rdWord;
  logic              w_unused;

  assign w_idx    = paddr[ADDR_W-1:OFFS_W];
  assign w_err    = ({1'b0, w_idx} >= DEPTH_V) || (pwrite && (w_idx == '0));
  assign w_setup  = (r_state == IDLE) && psel && !penable;
  assign w_commit = (r_state == ACCESS) && w_done && psel && penable && r_write && !r_err;
  assign w_rdWord = (r_idx == '0) ? ID_VALUE[DATA_W-1:0] : r_mem[r_idx[MEM_AW-1:0]];
  assign w_unused = ^{1'b0, paddr, pstrb};

`ifdef APB_REGFILE_PSTRB_EN
  assign w_strb = pstrb;
`else
  assign w_strb = '1;
`endif

  apb_wait_ctr #(
    .W(4)
  ) u_waitCtr (
    .i_clock     (pclk),
    .i_reset     (preset),
    .i_load      (w_setup),
    .i_loadValue (4'(WAIT_STATES)),
    .o_done      (w_done)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A dropped psel aborts the access; completion needs the full access phase.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (psel && !penable) w_nextState = ACCESS;
      ACCESS:  if (!psel || (w_done && penable)) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if ((r_state == ACCESS) && w_done) begin
      pready  = 1'b1;
      pslverr = r_err;
      if (!r_write && !r_err) prdata = w_rdWord;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_idx   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_setup) begin
      r_idx   <= w_idx;
      r_write <= pwrite;
      r_err   <= w_err;
      r_wdata <= pwdata;
      r_strb  <= w_strb;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (r_strb[b]) r_mem[r_idx[MEM_AW-1:0]][b*8 +: 8] <= r_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench: two slaves (0 and 3 wait states) on a shared bus,
// checked against a word-array model of the register file.
module tb_apb_regfile_slave;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        clk;
  logic        preset;
  logic        pselA, pselB;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        preadyA, preadyB;
  logic        pslverrA, pslverrB;
  logic [31:0] prdataA, prdataB;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [2][16];

  apb_regfile_slave #(.WAIT_STATES(0)) dutA (
    .pclk(clk), .preset(preset), .psel(pselA), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(preadyA), .prdata(prdataA), .pslverr(pslverrA)
  );

  apb_regfile_slave #(.WAIT_STATES(3)) dutB (
    .pclk(clk), .preset(preset), .psel(pselB), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(preadyB), .prdata(prdataB), .pslverr(pslverrB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
  endtask

  // One complete transfer starting at a negedge; returns at the negedge
  // after completion with the bus idle, so the next call is back-to-back.
  task automatic applyStimulus(input bit toB, input bit wr, input logic [7:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    int          idx;
    int          n;
    bit          expErr;
    logic [31:0] expData;
    logic [31:0] rd;
    logic        err;
    logic        rdy;
    idx     = int'(addr) / 4;
    expErr  = (idx >= 16) || (wr && idx == 0);
    expData = 32'h0;
    if (!wr && !expErr) expData = (idx == 0) ? ID : model[toB][idx];

    pselA = !toB; pselB = toB; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1;
    n = 1;
    while (!(toB ? preadyB : preadyA) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(toB ? "latencyB" : "latencyA", n, toB ? 32'd4 : 32'd1);
    rd  = toB ? prdataB : prdataA;
    err = toB ? pslverrB : pslverrA;
    checkOutput(wr ? "writeData" : "readData", rd, expData);
    checkOutput("pslverr", {31'b0, err}, {31'b0, expErr});

    if (wr && !expErr) begin
`ifdef APB_REGFILE_PSTRB_EN
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[toB][idx][b*8 +: 8] = data[b*8 +: 8];
`else
      model[toB][idx] = data;
`endif
    end

    @(posedge clk);
    @(negedge clk);
    pselA = 1'b0; pselB = 1'b0; penable = 1'b0;
    rdy = toB ? preadyB : preadyA;
    checkOutput("readyAfterDone", {31'b0, rdy}, 32'h0);
  endtask

  task automatic doReset();
    preset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    preset = 1'b0;
    clearModel();
  endtask

  initial begin
    preset = 1'b1; pselA = 1'b0; pselB = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0;
    clearModel();
    @(negedge clk);
    doReset();

    checkOutput("rstReadyA", {31'b0, preadyA}, 32'h0);
    checkOutput("rstErrA", {31'b0, pslverrA}, 32'h0);
    checkOutput("rstDataA", prdataA, 32'h0);
    checkOutput("rstReadyB", {31'b0, preadyB}, 32'h0);

    // ID word and a cleared word, zero wait states
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 8'h0C, 32'h0, 4'h0);

    // Write then read back, including an unaligned byte address
    applyStimulus(1'b0, 1'b1, 8'h0C, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1'b0, 1'b0, 8'h0C, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 8'h0E, 32'h0, 4'h0);

    // Three wait states
    applyStimulus(1'b1, 1'b1, 8'h08, 32'h5A5A_1234, 4'hF);
    applyStimulus(1'b1, 1'b0, 8'h08, 32'h0, 4'h0);

    // Error responses: ID write and out-of-range read
    applyStimulus(1'b0, 1'b1, 8'h00, 32'h1234_5678, 4'hF);
    applyStimulus(1'b0, 1'b0, 8'h40, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b1, 8'h44, 32'h0BAD_0BAD, 4'hF);

    // Byte strobes (model decides which bytes land)
    applyStimulus(1'b0, 1'b1, 8'h10, 32'h1122_3344, 4'hF);
    applyStimulus(1'b0, 1'b1, 8'h10, 32'hAABB_CCDD, 4'b0101);
    applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 8'h10, 32'hFFFF_FFFF, 4'b0000);
    applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 4'h0);

    // penable high during what should be setup is ignored
    pselA = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h00;
    repeat (2) begin
      @(negedge clk);
      checkOutput("ignoredSetup", {31'b0, preadyA}, 32'h0);
    end
    pselA = 1'b0; penable = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);

    // psel dropped mid-write on the wait-state slave
    applyStimulus(1'b1, 1'b1, 8'h14, 32'h1234_5678, 4'hF);
    pselB = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    pselB = 1'b0; penable = 1'b0;
    @(negedge clk);
    checkOutput("dropReady", {31'b0, preadyB}, 32'h0);
    checkOutput("dropErr", {31'b0, pslverrB}, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h14, 32'h0, 4'h0);

    // Reset during a write
    pselB = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h18; pwdata = 32'h7777_8888; pstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1;
    preset  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    preset = 1'b0; pselB = 1'b0; penable = 1'b0;
    clearModel();
    checkOutput("rstMidReady", {31'b0, preadyB}, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h18, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 8'h14, 32'h0, 4'h0);

    // Randomised traffic across both slaves, including out-of-range words
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom % 2), 1'($urandom % 2), 8'($urandom_range(0, 8'h4F)),
                    $urandom, 4'($urandom % 16));
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 8'(i * 4), 32'h0, 4'h0);
      applyStimulus(1'b1, 1'b0, 8'(i * 4 + 1), 32'h0, 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
